// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the byte count of an access size.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_WR0,
        ST_RD1,
        ST_WR1,
        ST_RESP
    } state_e;

    // Illegal size 3 reports 4 bytes; it is trapped as an error before any access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit.
// Merges store bytes into the w0/w1 words and extracts and extends load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] buf0,
    input  logic [31:0] buf1,
    output logic [31:0] merged0,
    output logic [31:0] merged1,
    output logic [31:0] rdata
);

    logic [2:0]  nbytes;
    logic [7:0]  lane_mask;
    logic [63:0] wdata_lanes;
    logic [31:0] raw;

    assign nbytes = size_bytes(size);

    // Lanes 0-3 belong to w0 and lanes 4-7 to w1 of the 64-bit {w1,w0} window.
    assign lane_mask   = ((8'd1 << nbytes) - 8'd1) << off;
    assign wdata_lanes = {32'd0, wdata} << {off, 3'b000};
    assign raw         = 32'({buf1, buf0} >> {off, 3'b000});

    always_comb begin
        merged0 = buf0;
        merged1 = buf1;
        for (int i = 0; i < 4; i++) begin
            if (lane_mask[i])
                merged0[8*i +: 8] = wdata_lanes[8*i +: 8];
            if (lane_mask[i+4])
                merged1[8*i +: 8] = wdata_lanes[32+8*i +: 8];
        end
    end

    always_comb begin
        case (size)
            SZ_B:    rdata = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
            SZ_H:    rdata = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            default: rdata = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word accesses at any byte address into
// word accesses, using read-modify-write for sub-word stores and splitting word-crossing accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic        mem_ren,
    input  logic [31:0] mem_rdata
);

    state_e      state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf0;
    logic [31:0] buf1;
    logic [29:0] last_addr;

    logic [1:0]  off;
    logic [3:0]  span;
    logic        split;
    logic [29:0] w0;
    logic [29:0] w1;

    logic [3:0]  req_span;
    logic        req_split;
    logic        req_err;
    logic        req_full_word;

    logic [31:0] buf0_nxt;
    logic [31:0] buf1_nxt;
    logic [31:0] merged0;
    logic [31:0] merged1;
    logic [31:0] load_data;

    assign off   = addr_q[1:0];
    assign span  = {2'b00, off} + {1'b0, size_bytes(size_q)};
    assign split = span > 4'd4;
    assign w0    = addr_q[31:2];
    assign w1    = w0 + 30'd1;

    assign req_span      = {2'b00, req_addr[1:0]} + {1'b0, size_bytes(req_size)};
    assign req_split     = req_span > 4'd4;
    assign req_err       = (req_size == 2'd3) || (req_split && !MISALIGNED_EN);
    assign req_full_word = req_we && (req_size == SZ_W) && (req_addr[1:0] == 2'b00);

    // Forward the word being read this cycle so the response can be registered on the same edge.
    assign buf0_nxt = (state == ST_RD0) ? mem_rdata : buf0;
    assign buf1_nxt = (state == ST_RD1) ? mem_rdata : buf1;

    lsu_align u_align (
        .off         (off),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .buf0        (buf0_nxt),
        .buf1        (buf1_nxt),
        .merged0     (merged0),
        .merged1     (merged1),
        .rdata       (load_data)
    );

    assign req_ready = (state == ST_IDLE) && !rst;
    assign mem_ren   = (state == ST_RD0) || (state == ST_RD1);
    assign mem_wen   = ((state == ST_WR0) || (state == ST_WR1)) && !rst;
    assign mem_wdata = (state == ST_WR1) ? merged1 : merged0;

    always_comb begin
        case (state)
            ST_RD0, ST_WR0: mem_addr = w0;
            ST_RD1, ST_WR1: mem_addr = w1;
            default:        mem_addr = last_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            buf0       <= '0;
            buf1       <= '0;
            last_addr  <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            if (mem_ren || mem_wen)
                last_addr <= mem_addr;

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_full_word) begin
                            state <= ST_WR0;
                        end else begin
                            state <= ST_RD0;
                        end
                    end
                end
                ST_RD0: begin
                    buf0 <= mem_rdata;
                    if (we_q) begin
                        state <= ST_WR0;
                    end else if (split) begin
                        state <= ST_RD1;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end
                ST_WR0: begin
                    if (split) begin
                        state <= ST_RD1;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                    end
                end
                ST_RD1: begin
                    buf1 <= mem_rdata;
                    if (we_q) begin
                        state <= ST_WR1;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end
                ST_WR1: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model per instance and
// a queue of expected responses popped as each response arrives.
module tb_load_store_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_valid_na;
    logic        req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_err, mem_wen, mem_ren;
    logic [31:0] resp_rdata, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;

    logic        req_ready_na, resp_valid_na, resp_err_na, mem_wen_na, mem_ren_na;
    logic [31:0] resp_rdata_na, mem_wdata_na, mem_rdata_na;
    logic [29:0] mem_addr_na;

    load_store_unit #(.MISALIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.MISALIGNED_EN(1'b0)) dut_na (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_na), .req_ready(req_ready_na), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_na), .resp_rdata(resp_rdata_na),
        .resp_err(resp_err_na), .mem_addr(mem_addr_na), .mem_wdata(mem_wdata_na),
        .mem_wen(mem_wen_na), .mem_ren(mem_ren_na), .mem_rdata(mem_rdata_na)
    );

    logic [31:0] mem    [64];
    logic [31:0] mem_na [64];
    assign mem_rdata    = mem[mem_addr[5:0]];
    assign mem_rdata_na = mem_na[mem_addr_na[5:0]];

    logic        bd_we = 1'b0;
    logic        bd_na = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;
    int wen_cnt = 0, ren_cnt = 0, resp_cnt = 0, wen_cnt_na = 0, ren_cnt_na = 0;
    logic [29:0] last_wen_addr = '0, last_wen_addr_na = '0;

    always @(negedge clk) begin
        if (mem_wen) begin
            mem[mem_addr[5:0]] <= mem_wdata;
            last_wen_addr      <= mem_addr;
            wen_cnt            <= wen_cnt + 1;
        end
        if (mem_wen_na) begin
            mem_na[mem_addr_na[5:0]] <= mem_wdata_na;
            last_wen_addr_na         <= mem_addr_na;
            wen_cnt_na               <= wen_cnt_na + 1;
        end
        if (mem_ren)    ren_cnt    <= ren_cnt + 1;
        if (mem_ren_na) ren_cnt_na <= ren_cnt_na + 1;
        if (resp_valid) resp_cnt   <= resp_cnt + 1;
        if (bd_we && !bd_na) mem[bd_idx]    <= bd_data;
        if (bd_we && bd_na)  mem_na[bd_idx] <= bd_data;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input bit na, input int idx, input logic [31:0] d);
        bd_na   = na;
        bd_idx  = 6'(idx);
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic do_req(input string tag, input bit na, input bit we, input logic [1:0] size,
                          input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat);
        exp_t e;
        exp_t got;
        int   n;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        n = 0;
        while (!(na ? req_ready_na : req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (na) req_valid_na = 1'b1;
        else    req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_valid_na = 1'b0;
        req_wdata    = 32'h0BAD_0BAD;
        req_addr     = 32'h0000_0000;
        n = 1;
        while (!(na ? resp_valid_na : resp_valid) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        got = sb.pop_front();
        check({tag, ".rdata"}, na ? resp_rdata_na : resp_rdata, got.rdata);
        check({tag, ".err"}, 32'(na ? resp_err_na : resp_err), 32'(got.err));
        check({tag, ".lat"}, 32'(n), 32'(got.lat));
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, 32'(na ? resp_valid_na : resp_valid), 32'd0);
    endtask

    initial begin
        int w_s, r_s, wn_s, rn_s, rsp_s;
        rst = 1'b1;
        req_valid = 1'b0; req_valid_na = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.wen", 32'(mem_wen), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.ready_after", 32'(req_ready), 32'd1);

        poke(0, 5, 32'h8899AABB);
        do_req("lb", 0, 0, 2'd0, 0, 32'h15, 32'h0, 32'hFFFFFFAA, 0, 2);
        do_req("lbu", 0, 0, 2'd0, 1, 32'h15, 32'h0, 32'h000000AA, 0, 2);

        poke(0, 5, 32'h11223344);
        w_s = wen_cnt;
        do_req("sb", 0, 1, 2'd0, 0, 32'h16, 32'h000000EE, 32'h0, 0, 3);
        check("sb.mem5", mem[5], 32'h11EE3344);
        check("sb.wen_cycles", 32'(wen_cnt - w_s), 32'd1);
        check("sb.wen_addr", 32'(last_wen_addr), 32'd5);

        poke(0, 5, 32'h44332211);
        poke(0, 6, 32'h88776655);
        do_req("lw_split", 0, 0, 2'd2, 0, 32'h17, 32'h0, 32'h77665544, 0, 3);
        w_s = wen_cnt;
        do_req("sw_split", 0, 1, 2'd2, 0, 32'h17, 32'hDDCCBBAA, 32'h0, 0, 5);
        check("sw_split.mem5", mem[5], 32'hAA332211);
        check("sw_split.mem6", mem[6], 32'h88DDCCBB);
        check("sw_split.wen_cycles", 32'(wen_cnt - w_s), 32'd2);

        do_req("lh", 0, 0, 2'd1, 0, 32'h16, 32'h0, 32'hFFFFAA33, 0, 2);
        do_req("lhu", 0, 0, 2'd1, 1, 32'h16, 32'h0, 32'h0000AA33, 0, 2);

        r_s = ren_cnt;
        do_req("sw_aligned", 0, 1, 2'd2, 0, 32'h20, 32'h12345678, 32'h0, 0, 2);
        check("sw_aligned.mem8", mem[8], 32'h12345678);
        check("sw_aligned.no_read", 32'(ren_cnt - r_s), 32'd0);
        do_req("lw_aligned", 0, 0, 2'd2, 0, 32'h20, 32'h0, 32'h12345678, 0, 2);

        poke(0, 63, 32'h00112233);
        poke(0, 0, 32'h44556677);
        do_req("sh_wrap", 0, 1, 2'd1, 0, 32'hFFFFFFFF, 32'h0000BEEF, 32'h0, 0, 5);
        check("sh_wrap.mem_top", mem[63], 32'hEF112233);
        check("sh_wrap.mem0", mem[0], 32'h445566BE);
        check("sh_wrap.w1_addr", 32'(last_wen_addr), 32'd0);
        do_req("lh_wrap", 0, 0, 2'd1, 0, 32'hFFFFFFFF, 32'h0, 32'hFFFFBEEF, 0, 3);

        w_s = wen_cnt;
        r_s = ren_cnt;
        do_req("illegal_ld", 0, 0, 2'd3, 0, 32'h14, 32'h0, 32'h0, 1, 1);
        do_req("illegal_st", 0, 1, 2'd3, 0, 32'h14, 32'hFFFFFFFF, 32'h0, 1, 1);
        check("illegal.no_mem", 32'((wen_cnt - w_s) + (ren_cnt - r_s)), 32'd0);
        check("illegal.mem5", mem[5], 32'hAA332211);

        poke(1, 4, 32'h01020304);
        poke(1, 5, 32'hCAFEF00D);
        wn_s = wen_cnt_na;
        rn_s = ren_cnt_na;
        do_req("na_lh_split", 1, 0, 2'd1, 0, 32'h13, 32'h0, 32'h0, 1, 1);
        do_req("na_sw_split", 1, 1, 2'd2, 0, 32'h17, 32'h55555555, 32'h0, 1, 1);
        check("na.no_mem", 32'((wen_cnt_na - wn_s) + (ren_cnt_na - rn_s)), 32'd0);
        do_req("na_lw", 1, 0, 2'd2, 0, 32'h14, 32'h0, 32'hCAFEF00D, 0, 2);
        do_req("na_sb", 1, 1, 2'd0, 0, 32'h14, 32'h0000005A, 32'h0, 0, 3);
        check("na_sb.mem5", mem_na[5], 32'hCAFEF05A);
        check("na_sb.wen_addr", 32'(last_wen_addr_na), 32'd5);

        // Reset arrives while a split store sits in WR1.
        poke(0, 5, 32'h44332211);
        poke(0, 6, 32'h88776655);
        w_s   = wen_cnt;
        rsp_s = resp_cnt;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h17; req_wdata = 32'hDDCCBBAA;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort.in_wr1", 32'(mem_wen), 32'd1);
        rst = 1'b1;
        #1;
        check("abort.wen_gated", 32'(mem_wen), 32'd0);
        check("abort.ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort.ready_next", 32'(req_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("abort.no_resp", 32'(resp_cnt - rsp_s), 32'd0);
        check("abort.wen_cycles", 32'(wen_cnt - w_s), 32'd1);
        check("abort.mem5", mem[5], 32'hAA332211);
        check("abort.mem6", mem[6], 32'h88776655);

        do_req("post_abort_lw", 0, 0, 2'd2, 0, 32'h14, 32'h0, 32'hAA332211, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
